// File: rtl/l7_data_mem.sv
// Synchronous-write, pipelined-read data memory with request/ready handshake.
// After every reset a clear sequencer fills the whole array with INIT_VAL before RUN.
module l7_data_mem #(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          RD_LAT   = 1,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              MemWr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ready,
  output logic [DATA_W-1:0] DataOut,
  output logic              rd_valid
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PtrLast = '1;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("l7_data_mem: RD_LAT must be in 1..3");
  end

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_acc, wr_acc;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  assign ready  = (state_q == StRun);
  assign rd_acc = req & ready & ~MemWr;
  assign wr_acc = req & ready & MemWr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + ADDR_W'(1);
        // Exit decoded on the last address, not on pointer wrap.
        if (ptr_q == PtrLast) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage has no reset; the clear sequencer owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[ptr_q] <= INIT_VAL;
    end else if (wr_acc) begin
      mem_q[address] <= DataIn;
    end
  end

  // Data is captured at acceptance so later writes cannot leak into an in-flight read.
  // Each stage only loads on a valid beat, so the last stage holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= mem_q[address];
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign DataOut  = dat_q[RD_LAT-1];
  assign rd_valid = vld_q[RD_LAT-1];

endmodule

// File: tb/tb_l7_data_mem.sv
// Bench for l7_data_mem: a 16-word instance for clear length, plus three 64-word
// instances (RD_LAT 1..3) driven identically and scored against one array model.
module tb_l7_data_mem;

  localparam logic [15:0] Init = 16'hA5A5;
  localparam int BigDepth = 64;

  logic        clk = 1'b0;
  logic        rst_small_n, rst_big_n;
  logic        req, mem_wr;
  logic [5:0]  address;
  logic [15:0] data_in;

  logic        s_rdy, s_vld;
  logic [15:0] s_dout;
  logic        rdy  [1:3];
  logic        vld  [1:3];
  logic [15:0] dout [1:3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l7_data_mem #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .INIT_VAL(Init)) u_small (
    .clk(clk), .rst_n(rst_small_n), .req(req), .MemWr(mem_wr), .address(address[3:0]),
    .DataIn(data_in), .ready(s_rdy), .DataOut(s_dout), .rd_valid(s_vld));

  l7_data_mem #(.DATA_W(16), .ADDR_W(6), .RD_LAT(1), .INIT_VAL(Init)) u_lat1 (
    .clk(clk), .rst_n(rst_big_n), .req(req), .MemWr(mem_wr), .address(address),
    .DataIn(data_in), .ready(rdy[1]), .DataOut(dout[1]), .rd_valid(vld[1]));

  l7_data_mem #(.DATA_W(16), .ADDR_W(6), .RD_LAT(2), .INIT_VAL(Init)) u_lat2 (
    .clk(clk), .rst_n(rst_big_n), .req(req), .MemWr(mem_wr), .address(address),
    .DataIn(data_in), .ready(rdy[2]), .DataOut(dout[2]), .rd_valid(vld[2]));

  l7_data_mem #(.DATA_W(16), .ADDR_W(6), .RD_LAT(3), .INIT_VAL(Init)) u_lat3 (
    .clk(clk), .rst_n(rst_big_n), .req(req), .MemWr(mem_wr), .address(address),
    .DataIn(data_in), .ready(rdy[3]), .DataOut(dout[3]), .rd_valid(vld[3]));

  // Reference model: array contents, edges since reset, and one entry per edge
  // recording whether a read was accepted there and what it must return.
  typedef struct packed {logic v; logic [15:0] d;} rd_t;
  logic [15:0] ref_mem [BigDepth];
  rd_t         hist [$];
  int          edges;
  logic [15:0] exp_dout [1:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edges = 0;
    hist.delete();
    for (int l = 1; l <= 3; l++) exp_dout[l] = '0;
  endtask

  task automatic model_edge();
    rd_t e;
    bit  rdy_now;
    e = '0;
    rdy_now = (edges >= BigDepth);
    if (rdy_now && req) begin
      if (mem_wr) ref_mem[address] = data_in;
      else e = '{v: 1'b1, d: ref_mem[address]};
    end
    if (!rdy_now && edges == BigDepth - 1) begin
      for (int a = 0; a < BigDepth; a++) ref_mem[a] = Init;
    end
    edges++;
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
    for (int l = 1; l <= 3; l++) begin
      if (hist.size() >= l) begin
        if (hist[l-1].v) exp_dout[l] = hist[l-1].d;
      end
    end
  endtask

  task automatic compare_all();
    logic ev;
    for (int l = 1; l <= 3; l++) begin
      ev = 1'b0;
      if (hist.size() >= l) ev = hist[l-1].v;
      chk($sformatf("ready_L%0d_e%0d", l, edges), 32'(rdy[l]), 32'(edges >= BigDepth));
      chk($sformatf("rd_valid_L%0d_e%0d", l, edges), 32'(vld[l]), 32'(ev));
      chk($sformatf("DataOut_L%0d_e%0d", l, edges), 32'(dout[l]), 32'(exp_dout[l]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic w, input logic [5:0] a, input logic [15:0] d);
    req = r; mem_wr = w; address = a; data_in = d;
  endtask

  initial begin
    rst_small_n = 1'b0;
    rst_big_n   = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_small_ready", 32'(s_rdy), 32'd0);
    chk("reset_small_valid", 32'(s_vld), 32'd0);
    chk("reset_small_dout", 32'(s_dout), 32'd0);
    compare_all();

    // Clear length on the 16-word instance, then read every word back.
    rst_small_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      chk($sformatf("small_ready_e%0d", e), 32'(s_rdy), 32'(e >= 16));
    end
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b0, 6'(a), 16'h0);
      @(posedge clk); #1;
      chk($sformatf("small_rd_valid_a%0d", a), 32'(s_vld), 32'd1);
      chk($sformatf("small_rd_data_a%0d", a), 32'(s_dout), 32'(Init));
    end
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    @(posedge clk); #1;
    chk("small_valid_drop", 32'(s_vld), 32'd0);
    chk("small_dout_hold", 32'(s_dout), 32'(Init));
    rst_small_n = 1'b0;

    // Write request held through CLEAR must be ignored.
    drive(1'b1, 1'b1, 6'd3, 16'h1234);
    rst_big_n = 1'b1;
    model_reset();
    repeat (BigDepth) step();
    drive(1'b1, 1'b0, 6'd3, 16'h0);
    step();
    chk("clear_ignores_write", 32'(dout[1]), 32'(Init));

    // Read-after-write.
    drive(1'b1, 1'b1, 6'd48, 16'h000B);
    step();
    drive(1'b1, 1'b0, 6'd48, 16'h0);
    step();
    chk("raw_data", 32'(dout[1]), 32'h000B);

    // Preload 49..52, then back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 6'(49 + i), 16'(i + 1));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'(49 + i), 16'h0);
      step();
    end
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    repeat (4) step();
    chk("pipe_last_L3", 32'(dout[3]), 32'd4);

    // Randomised traffic, biased toward a few addresses to hit read-after-write.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom % 4) != 0, $urandom % 2,
            ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom % 64), 16'($urandom));
      step();
    end

    // Idle hold: DataOut keeps the last read value across a write and idle cycles.
    drive(1'b1, 1'b1, 6'd5, 16'h0055);
    step();
    drive(1'b1, 1'b0, 6'd5, 16'h0);
    step();
    drive(1'b1, 1'b1, 6'd5, 16'hFFFF);
    step();
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    repeat (10) step();
    chk("idle_hold_L2", 32'(dout[2]), 32'h0055);

    // Asynchronous reset with a read in flight.
    drive(1'b1, 1'b0, 6'd48, 16'h0);
    step();
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    #1 rst_big_n = 1'b0;
    #1;
    for (int l = 1; l <= 3; l++) begin
      chk($sformatf("async_rst_ready_L%0d", l), 32'(rdy[l]), 32'd0);
      chk($sformatf("async_rst_valid_L%0d", l), 32'(vld[l]), 32'd0);
      chk($sformatf("async_rst_dout_L%0d", l), 32'(dout[l]), 32'd0);
    end
    model_reset();
    #1 rst_big_n = 1'b1;
    repeat (BigDepth) step();
    drive(1'b1, 1'b0, 6'd48, 16'h0);
    step();
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    repeat (3) step();
    chk("post_reclear_L3", 32'(dout[3]), 32'(Init));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
